// File: rtl/adc_lvds_axi_regs.sv
// AXI4-Lite slave exposing four 32-bit control registers for the LVDS ADC.
// Define ADC_LVDS_AXI_SLVERR_EN to answer SLVERR on slots 4-7.
module adc_lvds_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] slv_regs
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;

`ifdef ADC_LVDS_AXI_SLVERR_EN
  localparam logic SLVERR = 1'b1;
`else
  localparam logic SLVERR = 1'b0;
`endif

  logic [DW-1:0] regs [4];
  logic          wr_rdy;
  logic          wr_go;
  logic          rd_go;
  logic [2:0]    wslot;
  logic [2:0]    rslot;
  logic          unused;

  assign unused = ^{s00_axi_awprot, s00_axi_arprot,
                    s00_axi_awaddr, s00_axi_araddr};

  assign wslot = s00_axi_awaddr[4:2];
  assign rslot = s00_axi_araddr[4:2];

  assign s00_axi_awready = wr_rdy;
  assign s00_axi_wready  = wr_rdy;

  assign wr_go = wr_rdy && s00_axi_awvalid && s00_axi_wvalid;
  assign rd_go = s00_axi_arready && s00_axi_arvalid;

  assign slv_regs = {regs[3], regs[2], regs[1], regs[0]};

  // Slots 4-7 have no storage; only the response code may flag them.
  function automatic logic [1:0] resp_of(input logic [2:0] slot);
    return {slot[2] & SLVERR, 1'b0};
  endfunction

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_rdy         <= 1'b0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= 2'b00;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      wr_rdy <= s00_axi_awvalid && s00_axi_wvalid &&
                !s00_axi_bvalid && !wr_rdy;
      if (wr_go) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= resp_of(wslot);
        if (!wslot[2]) begin
          for (int b = 0; b < NB; b++) begin
            if (s00_axi_wstrb[b])
              regs[wslot[1:0]][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
          end
        end
      end else if (s00_axi_bvalid && s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rresp   <= 2'b00;
      s00_axi_rdata   <= '0;
    end else begin
      s00_axi_arready <= s00_axi_arvalid && !s00_axi_rvalid &&
                         !s00_axi_arready;
      if (rd_go) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rresp  <= resp_of(rslot);
        s00_axi_rdata  <= rslot[2] ? '0 : regs[rslot[1:0]];
      end else if (s00_axi_rvalid && s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_lvds_axi_regs.sv
// Scoreboard bench for adc_lvds_axi_regs: stimulus queues expected
// responses, negedge monitors pop and compare on each B/R handshake.
module tb_adc_lvds_axi_regs;

`ifdef ADC_LVDS_AXI_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b1;
  logic [4:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b1;
  logic [127:0] slv_regs;

  int checks = 0;
  int errors = 0;

  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  logic [1:0]  bexp;
  logic [33:0] rexp;

  always #5 clk = ~clk;

  adc_lvds_axi_regs dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .slv_regs        (slv_regs)
  );

  always @(negedge clk) begin
    if (bvalid && bready) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected got bresp=%b", bresp);
      end else begin
        bexp = bq.pop_front();
        if (bresp !== bexp) begin
          errors++;
          $display("FAIL bresp got %b want %b", bresp, bexp);
        end
      end
    end
    if (rvalid && rready) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected got rdata=%h", rdata);
      end else begin
        rexp = rq.pop_front();
        if ({rdata, rresp} !== rexp) begin
          errors++;
          $display("FAIL rdata got %h/%b want %h/%b",
                   rdata, rresp, rexp[33:2], rexp[1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout got none want handshake", name);
  endtask

  task automatic wait_aw();
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(awready && wready) && n < 20);
    if (!(awready && wready)) timeout("aw_w_ready");
  endtask

  task automatic wait_ar();
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!arready && n < 20);
    if (!arready) timeout("arready");
  endtask

  task automatic wait_bq();
    int n = 0;
    while (bq.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (bq.size() != 0) begin timeout("bvalid"); bq.delete(); end
  endtask

  task automatic wait_rq();
    int n = 0;
    while (rq.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (rq.size() != 0) begin timeout("rvalid"); rq.delete(); end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] r);
    bq.push_back(r);
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    wait_aw();
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_bq();
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] d,
                    input logic [1:0] r);
    rq.push_back({d, r});
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    wait_ar();
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_rq();
  endtask

  logic [31:0] init_v [4];
  logic [127:0] snap;

  initial begin
    init_v[0] = 32'h0101FFFF;
    init_v[1] = 32'hABCD0001;
    init_v[2] = 32'hDEAD0011;
    init_v[3] = 32'hBEEF0011;

    repeat (2) @(posedge clk);
    #2;
    chk("reset_outs", {awready, wready, bvalid, bresp, arready,
                       rvalid, rresp, rdata},
        '0);
    chk("reset_regs", slv_regs, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      wr(5'(4 * i), init_v[i], 4'hF, 2'b00);
    for (int i = 0; i < 4; i++)
      rd(5'(4 * i), init_v[i], 2'b00);
    chk("slv_regs_init", slv_regs,
        {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'h0101FFFF});

    wr(5'h05, 32'h12345678, 4'b0101, 2'b00);
    rd(5'h04, 32'hAB340078, 2'b00);

    bready = 1'b0;
    bq.push_back(2'b00);
    bq.push_back(2'b00);
    @(posedge clk); #1;
    awaddr = 5'h0C; wdata = 32'h11112222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    wait_aw();
    @(posedge clk); #1;
    wdata = 32'h33334444;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_hold_block", {bvalid, awready, wready}, 3'b100);
    end
    chk("b_hold_data", slv_regs[127:96], 32'h11112222);
    bready = 1'b1;
    wait_aw();
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_bq();
    chk("second_write", slv_regs[127:96], 32'h33334444);

    snap = slv_regs;
    wr(5'h10, 32'hFFFFFFFF, 4'hF, ERR);
    rd(5'h14, 32'h0, ERR);
    rd(5'h10, 32'h0, ERR);
    chk("unimpl_regs", slv_regs, snap);

    fork
      wr(5'h08, 32'h0, 4'hF, 2'b00);
      rd(5'h08, 32'hDEAD0011, 2'b00);
    join
    rd(5'h08, 32'h0, 2'b00);
    chk("same_cycle_reg", slv_regs[95:64], 32'h0);

    rready = 1'b0;
    @(posedge clk); #1;
    araddr = 5'h00; arvalid = 1'b1;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!rvalid && n < 20);
      if (!rvalid) timeout("rvalid_pre_reset");
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_abort", {rvalid, arready, rdata}, '0);
    chk("reset_abort_regs", slv_regs, '0);
    arvalid = 1'b0;
    rready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      rd(5'(4 * i), 32'h0, 2'b00);

    repeat (3) @(posedge clk);
    chk("queues_empty", 128'(bq.size() + rq.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
